// File: rtl/if_fetch_buf.sv
// IF->ID decoupling FIFO of {pc, instr} pairs; flush drops all entries. Optional IF_FB_STATS_EN adds push/stall counters.
// Latency: one cycle from an accepted push to id_valid; no same-cycle bypass.
// Backpressure: fetch_ready = !full from registered count only, so id_ready has no combinational path to fetch.
module if_fetch_buf #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic        flush,
  output logic [29:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  input  logic        id_ready
`ifdef IF_FB_STATS_EN
  ,
  output logic [31:0] fb_fetch_cnt,
  output logic [31:0] fb_stall_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [29:0]   storage_pc    [DEPTH];
  logic [31:0]   storage_instr [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;

  assign fetch_ready = (count != CW'(DEPTH));
  assign id_valid    = (count != '0);
  assign push        = fetch_valid && fetch_ready;
  assign pop         = id_valid && id_ready;

  // Empty buffer presents a NOP at PC 0 to the decoder.
  assign id_pc    = id_valid ? storage_pc[rd_ptr]    : '0;
  assign id_instr = id_valid ? storage_instr[rd_ptr] : '0;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // A flushed push may land in storage, but count stays 0 so it is never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      storage_pc[wr_ptr]    <= fetch_pc;
      storage_instr[wr_ptr] <= fetch_instr;
    end
  end

`ifdef IF_FB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_fetch_cnt <= '0;
      fb_stall_cnt <= '0;
    end else begin
      if (push)                      fb_fetch_cnt <= fb_fetch_cnt + 32'd1;
      if (fetch_valid && !fetch_ready) fb_stall_cnt <= fb_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf: latency, backpressure, flush, async reset, optional stats.
module tb_if_fetch_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        flush;
  logic [29:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        id_ready;
`ifdef IF_FB_STATS_EN
  logic [31:0] fb_fetch_cnt;
  logic [31:0] fb_stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  if_fetch_buf #(.DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_valid    (id_valid),
    .id_ready    (id_ready)
`ifdef IF_FB_STATS_EN
    ,
    .fb_fetch_cnt(fb_fetch_cnt),
    .fb_stall_cnt(fb_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [29:0] pc, input logic [31:0] ins);
    fetch_valid = v;
    fetch_pc    = pc;
    fetch_instr = ins;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    id_ready = 1'b0;
    drive(1'b0, '0, '0);
    #12;
    check("rst_id_valid",    id_valid, 1'b0);
    check("rst_id_pc",       id_pc, 30'h0);
    check("rst_id_instr",    id_instr, 32'h0);
    check("rst_fetch_ready", fetch_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Single pair: one-cycle latency, then popped.
    drive(1'b1, 30'h0BFF, 32'h2008_0005);
    id_ready = 1'b1;
    #1;
    check("t2_pre_valid", id_valid, 1'b0);
    step();
    drive(1'b0, '0, '0);
    check("t2_valid", id_valid, 1'b1);
    check("t2_pc",    id_pc, 30'h0BFF);
    check("t2_instr", id_instr, 32'h2008_0005);
    step();
    check("t2_empty", id_valid, 1'b0);
    check("t2_ready", fetch_ready, 1'b1);

    // Fill while ID stalled; third pair held upstream.
    id_ready = 1'b0;
    drive(1'b1, 30'h100, 32'hA000_0100);
    step();
    check("t3_ready1", fetch_ready, 1'b1);
    drive(1'b1, 30'h101, 32'hA000_0101);
    step();
    check("t3_full_ready", fetch_ready, 1'b0);
    drive(1'b1, 30'h102, 32'hA000_0102);
    step();
    check("t3_hold_ready", fetch_ready, 1'b0);
    check("t3_hold_head",  id_pc, 30'h100);
    // Full with pop and fetch_valid: pop only.
    id_ready = 1'b1;
    step();
    check("t4_ready_rise", fetch_ready, 1'b1);
    check("t4_head",       id_pc, 30'h101);
    check("t4_head_instr", id_instr, 32'hA000_0101);
    step();
    drive(1'b0, '0, '0);
    check("t3_head_102",  id_pc, 30'h102);
    check("t3_instr_102", id_instr, 32'hA000_0102);
    check("t3_valid_102", id_valid, 1'b1);
    step();
    check("t3_drained", id_valid, 1'b0);

    // Flush when full with a same-cycle push and pop.
    id_ready = 1'b0;
    drive(1'b1, 30'h200, 32'hB000_0200);
    step();
    drive(1'b1, 30'h201, 32'hB000_0201);
    step();
    check("t5_full", fetch_ready, 1'b0);
    flush = 1'b1;
    id_ready = 1'b1;
    drive(1'b1, 30'h202, 32'hB000_0202);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("t5_flush_valid", id_valid, 1'b0);
    check("t5_flush_ready", fetch_ready, 1'b1);
    check("t5_flush_instr", id_instr, 32'h0);
    step();
    check("t5_not_stored", id_valid, 1'b0);
    drive(1'b1, 30'h300, 32'hC000_0300);
    step();
    drive(1'b0, '0, '0);
    check("t5_after_pc", id_pc, 30'h300);
    step();

    // Asynchronous reset mid-stream with two entries.
    id_ready = 1'b0;
    drive(1'b1, 30'h400, 32'hD000_0400);
    step();
    drive(1'b1, 30'h401, 32'hD000_0401);
    step();
    drive(1'b0, '0, '0);
    check("t1_full_valid", id_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t1_async_valid", id_valid, 1'b0);
    check("t1_async_instr", id_instr, 32'h0);
    check("t1_async_pc",    id_pc, 30'h0);
    check("t1_async_ready", fetch_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("t1_post_valid", id_valid, 1'b0);
    drive(1'b1, 30'h500, 32'hE000_0500);
    step();
    drive(1'b0, '0, '0);
    check("t1_first_pc", id_pc, 30'h500);
    id_ready = 1'b1;
    step();
    check("t1_popped", id_valid, 1'b0);

`ifdef IF_FB_STATS_EN
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rst_fetch", fb_fetch_cnt, 32'd0);
    check("t6_rst_stall", fb_stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    id_ready = 1'b0;
    drive(1'b1, 30'h600, 32'h0);
    step();
    drive(1'b1, 30'h601, 32'h1);
    step();
    step();
    step();
    step();
    drive(1'b0, '0, '0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_ready = 1'b1;
    drive(1'b1, 30'h602, 32'h2);
    step();
    drive(1'b1, 30'h603, 32'h3);
    step();
    drive(1'b1, 30'h604, 32'h4);
    step();
    drive(1'b0, '0, '0);
    check("t6_fetch_cnt", fb_fetch_cnt, 32'd5);
    check("t6_stall_cnt", fb_stall_cnt, 32'd3);
    check("t6_head_pc",   id_pc, 30'h604);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
